// File: rtl/exe_forward_stage_if.sv
// Execute-stage bundle: forwarded operands, ALU control and EXE/MEM outputs.
// The stage drives through the slave modport; the issuing side uses master.
interface exe_forward_stage_if;
    logic        freeze;
    logic        flush;
    logic [3:0]  EXE_CMD;
    logic        S;
    logic        imm;
    logic        WB_EN_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic [3:0]  Dest_in;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic [31:0] Val2_imm;
    logic [31:0] MEM_ALU_result;
    logic [31:0] WB_Value;
    logic [1:0]  Sel_src1;
    logic [1:0]  Sel_src2;

    logic        MEM_WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [3:0]  MEM_Dest;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic [3:0]  SR;

    modport slave (
        input  freeze, flush, EXE_CMD, S, imm,
        input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in,
        input  Val_Rn, Val_Rm, Val2_imm,
        input  MEM_ALU_result, WB_Value, Sel_src1, Sel_src2,
        output MEM_WB_EN, MEM_R_EN, MEM_W_EN, MEM_Dest,
        output ALU_result, ST_val, SR
    );

    modport master (
        output freeze, flush, EXE_CMD, S, imm,
        output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in,
        output Val_Rn, Val_Rm, Val2_imm,
        output MEM_ALU_result, WB_Value, Sel_src1, Sel_src2,
        input  MEM_WB_EN, MEM_R_EN, MEM_W_EN, MEM_Dest,
        input  ALU_result, ST_val, SR
    );
endinterface

// File: rtl/exe_forward_stage.sv
// Execute stage: operand forwarding, ALU with NZCV flags, EXE/MEM register.
// Priority on each edge is rst, then freeze, then flush, then normal load.
module exe_forward_stage (
    input logic clk,
    input logic rst,
    exe_forward_stage_if.slave bus
);

    logic [31:0] op_a;
    logic [31:0] rm_fwd;
    logic [31:0] op_b;
    logic [32:0] sum;
    logic [31:0] res;
    logic        c_new;
    logic        v_new;
    logic        flags_ok;
    logic [3:0]  flags;

    logic        wb_en_q, wb_en_d;
    logic        r_en_q, r_en_d;
    logic        w_en_q, w_en_d;
    logic [3:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic [31:0] st_val_q, st_val_d;
    logic [3:0]  sr_q, sr_d;

    always_comb begin
        op_a = bus.Val_Rn;
        case (bus.Sel_src1)
            2'b01:   op_a = bus.MEM_ALU_result;
            2'b10:   op_a = bus.WB_Value;
            default: op_a = bus.Val_Rn;
        endcase
        rm_fwd = bus.Val_Rm;
        case (bus.Sel_src2)
            2'b01:   rm_fwd = bus.MEM_ALU_result;
            2'b10:   rm_fwd = bus.WB_Value;
            default: rm_fwd = bus.Val_Rm;
        endcase
        op_b = bus.imm ? bus.Val2_imm : rm_fwd;
    end

    // Subtract forms add ~B so bit 32 is directly the NOT-borrow carry.
    always_comb begin
        sum      = '0;
        res      = '0;
        c_new    = sr_q[1];
        v_new    = sr_q[0];
        flags_ok = 1'b1;
        case (bus.EXE_CMD)
            4'b0001: res = op_b;
            4'b1001: res = ~op_b;
            4'b0010, 4'b0011: begin
                sum = {1'b0, op_a} + {1'b0, op_b}
                    + {32'd0, bus.EXE_CMD[0] & sr_q[1]};
                res   = sum[31:0];
                c_new = sum[32];
                v_new = (op_a[31] == op_b[31]) && (res[31] != op_a[31]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, op_a} + {1'b0, ~op_b}
                    + {32'd0, bus.EXE_CMD[0] ? sr_q[1] : 1'b1};
                res   = sum[31:0];
                c_new = sum[32];
                v_new = (op_a[31] != op_b[31]) && (res[31] != op_a[31]);
            end
            4'b0110: res = op_a & op_b;
            4'b0111: res = op_a | op_b;
            4'b1000: res = op_a ^ op_b;
            default: begin
                res      = '0;
                flags_ok = 1'b0;
            end
        endcase
        flags = flags_ok ? {res[31], res == 32'd0, c_new, v_new} : sr_q;
    end

    always_comb begin
        wb_en_d  = wb_en_q;
        r_en_d   = r_en_q;
        w_en_d   = w_en_q;
        dest_d   = dest_q;
        result_d = result_q;
        st_val_d = st_val_q;
        sr_d     = sr_q;
        if (!bus.freeze) begin
            if (bus.flush) begin
                wb_en_d  = 1'b0;
                r_en_d   = 1'b0;
                w_en_d   = 1'b0;
                dest_d   = '0;
                result_d = '0;
                st_val_d = '0;
            end else begin
                wb_en_d  = bus.WB_EN_in;
                r_en_d   = bus.MEM_R_EN_in;
                w_en_d   = bus.MEM_W_EN_in;
                dest_d   = bus.Dest_in;
                result_d = res;
                st_val_d = rm_fwd;
                if (bus.S) sr_d = flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q  <= 1'b0;
            r_en_q   <= 1'b0;
            w_en_q   <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
            st_val_q <= '0;
            sr_q     <= '0;
        end else begin
            wb_en_q  <= wb_en_d;
            r_en_q   <= r_en_d;
            w_en_q   <= w_en_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            st_val_q <= st_val_d;
            sr_q     <= sr_d;
        end
    end

    assign bus.MEM_WB_EN  = wb_en_q;
    assign bus.MEM_R_EN   = r_en_q;
    assign bus.MEM_W_EN   = w_en_q;
    assign bus.MEM_Dest   = dest_q;
    assign bus.ALU_result = result_q;
    assign bus.ST_val     = st_val_q;
    assign bus.SR         = sr_q;

endmodule

// File: tb/tb_exe_forward_stage.sv
// Directed bench for exe_forward_stage with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are read at the same point.
module tb_exe_forward_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exe_forward_stage_if bus ();

    exe_forward_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001;
    localparam logic [3:0] ADD = 4'b0010, ADC = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101;
    localparam logic [3:0] AND = 4'b0110, ORR = 4'b0111;
    localparam logic [3:0] EOR = 4'b1000, NOP = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register-immediate op with no forwarding, then one clock.
    task automatic op_imm(input logic [3:0] cmd, input logic s_v,
                          input logic [31:0] a, input logic [31:0] b);
        bus.EXE_CMD  = cmd;
        bus.S        = s_v;
        bus.Val_Rn   = a;
        bus.Val2_imm = b;
        bus.imm      = 1'b1;
        bus.Sel_src1 = 2'b00;
        bus.Sel_src2 = 2'b00;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.freeze = 0; bus.flush = 0; bus.EXE_CMD = NOP; bus.S = 0;
        bus.imm = 0; bus.WB_EN_in = 1; bus.MEM_R_EN_in = 1;
        bus.MEM_W_EN_in = 1; bus.Dest_in = 4'hA;
        bus.Val_Rn = 32'h11; bus.Val_Rm = 32'h22; bus.Val2_imm = 32'h33;
        bus.MEM_ALU_result = 0; bus.WB_Value = 0;
        bus.Sel_src1 = 0; bus.Sel_src2 = 0;
        step();
        step();
        check("rst_result", bus.ALU_result, 0);
        check("rst_stval", bus.ST_val, 0);
        check("rst_sr", {28'd0, bus.SR}, 0);
        check("rst_en", {29'd0, bus.MEM_WB_EN, bus.MEM_R_EN,
                         bus.MEM_W_EN}, 0);
        check("rst_dest", {28'd0, bus.MEM_Dest}, 0);
        rst = 1'b0;
        bus.WB_EN_in = 0; bus.MEM_R_EN_in = 0; bus.MEM_W_EN_in = 0;
        bus.Dest_in = 0;

        op_imm(SUB, 1, 5, 5);
        check("cmp_res", bus.ALU_result, 0);
        check("cmp_sr", {28'd0, bus.SR}, 4'b0110);
        op_imm(ADC, 1, 32'hFFFF_FFFF, 0);
        check("adc_res", bus.ALU_result, 0);
        check("adc_sr", {28'd0, bus.SR}, 4'b0110);
        op_imm(SUB, 1, 32'h8000_0000, 1);
        check("sub_res", bus.ALU_result, 32'h7FFF_FFFF);
        check("sub_sr", {28'd0, bus.SR}, 4'b0011);

        bus.MEM_ALU_result = 100;
        bus.EXE_CMD = ADD; bus.S = 0; bus.imm = 1;
        bus.Val_Rn = 5; bus.Val2_imm = 3; bus.Sel_src1 = 2'b01;
        step();
        check("fwd_mem_res", bus.ALU_result, 103);
        check("fwd_mem_sr", {28'd0, bus.SR}, 4'b0011);

        bus.Val_Rm = 7; bus.WB_Value = 32'hDEAD; bus.Sel_src2 = 2'b10;
        bus.Sel_src1 = 2'b00; bus.Val_Rn = 32'h100; bus.Val2_imm = 4;
        bus.MEM_W_EN_in = 1; bus.Dest_in = 4'h5;
        step();
        check("str_res", bus.ALU_result, 32'h104);
        check("str_stval", bus.ST_val, 32'hDEAD);
        check("str_wen", {31'd0, bus.MEM_W_EN}, 1);
        check("str_dest", {28'd0, bus.MEM_Dest}, 5);
        bus.MEM_W_EN_in = 0; bus.Dest_in = 0;

        bus.Sel_src1 = 2'b11; bus.Sel_src2 = 2'b00; bus.Val_Rn = 8;
        bus.MEM_ALU_result = 1; bus.Val2_imm = 2;
        step();
        check("rsvd_sel", bus.ALU_result, 10);

        bus.Sel_src1 = 2'b00; bus.Sel_src2 = 2'b01; bus.imm = 0;
        bus.Val_Rn = 1; bus.Val_Rm = 3; bus.MEM_ALU_result = 20;
        step();
        check("reg_b_res", bus.ALU_result, 21);
        check("reg_b_stval", bus.ST_val, 20);

        op_imm(AND, 1, 32'hF0F0, 32'h0FF0);
        check("and_res", bus.ALU_result, 32'h00F0);
        check("and_sr", {28'd0, bus.SR}, 4'b0011);
        op_imm(EOR, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("eor_res", bus.ALU_result, 0);
        check("eor_sr", {28'd0, bus.SR}, 4'b0111);
        op_imm(ORR, 1, 32'h8000_0000, 1);
        check("orr_res", bus.ALU_result, 32'h8000_0001);
        check("orr_sr", {28'd0, bus.SR}, 4'b1011);
        op_imm(MVN, 1, 0, 0);
        check("mvn_res", bus.ALU_result, 32'hFFFF_FFFF);
        op_imm(NOP, 1, 7, 7);
        check("nop_res", bus.ALU_result, 0);
        check("nop_sr", {28'd0, bus.SR}, 4'b1011);
        op_imm(SBC, 1, 10, 3);
        check("sbc_c1_res", bus.ALU_result, 7);
        check("sbc_c1_sr", {28'd0, bus.SR}, 4'b0010);
        op_imm(ADD, 1, 32'h7FFF_FFFF, 1);
        check("add_ovf_res", bus.ALU_result, 32'h8000_0000);
        check("add_ovf_sr", {28'd0, bus.SR}, 4'b1001);
        op_imm(SBC, 1, 10, 3);
        check("sbc_c0_res", bus.ALU_result, 6);
        check("sbc_c0_sr", {28'd0, bus.SR}, 4'b0010);
        op_imm(ADC, 1, 1, 1);
        check("adc_c1_res", bus.ALU_result, 3);
        check("adc_c1_sr", {28'd0, bus.SR}, 4'b0000);

        bus.WB_EN_in = 1; bus.Dest_in = 3;
        op_imm(ADD, 0, 4, 5);
        check("ld9_res", bus.ALU_result, 9);
        check("ld9_wb", {31'd0, bus.MEM_WB_EN}, 1);
        bus.freeze = 1; bus.flush = 1; bus.WB_EN_in = 0; bus.Dest_in = 7;
        for (int i = 0; i < 3; i++) begin
            op_imm(SUB, 1, 1, 2 + i);
            check("frz_res", bus.ALU_result, 9);
            check("frz_wb", {31'd0, bus.MEM_WB_EN}, 1);
            check("frz_dest", {28'd0, bus.MEM_Dest}, 3);
            check("frz_sr", {28'd0, bus.SR}, 0);
        end
        bus.freeze = 0;
        op_imm(SUB, 1, 1, 2);
        check("flush_res", bus.ALU_result, 0);
        check("flush_wb", {31'd0, bus.MEM_WB_EN}, 0);
        check("flush_sr", {28'd0, bus.SR}, 0);
        bus.flush = 0;

        bus.freeze = 1;
        op_imm(SUB, 1, 1, 2);
        check("frz2_sr", {28'd0, bus.SR}, 0);
        bus.freeze = 0;
        step();
        check("rel_res", bus.ALU_result, 32'hFFFF_FFFF);
        check("rel_sr", {28'd0, bus.SR}, 4'b1000);

        op_imm(SUB, 1, 32'h8000_0000, 1);
        op_imm(MOV, 0, 0, 32'h55);
        check("pre_rst_res", bus.ALU_result, 32'h55);
        check("pre_rst_sr", {28'd0, bus.SR}, 4'b0011);
        bus.freeze = 1; rst = 1;
        step();
        check("mid_rst_res", bus.ALU_result, 0);
        check("mid_rst_sr", {28'd0, bus.SR}, 0);
        check("mid_rst_wb", {31'd0, bus.MEM_WB_EN}, 0);
        rst = 0; bus.freeze = 0;
        op_imm(MOV, 1, 0, 32'h12);
        check("post_rst_res", bus.ALU_result, 32'h12);
        check("post_rst_sr", {28'd0, bus.SR}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
